// File: rtl/sdram_test_pkg.sv
// Shared FSM encoding, UART characters and address step for the SDRAM test master.
package sdram_test_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR,
        WR_WAIT,
        RD,
        RD_WAIT,
        CMP,
        PRINT,
        PRINT_WAIT,
        DONE
    } state_t;

    // Which UART character is being emitted in the PRINT/PRINT_WAIT loop
    typedef enum logic [1:0] {
        PR_WORD,
        PR_VERDICT,
        PR_LF
    } print_phase_t;

    localparam logic [7:0] CH_DOT = 8'h2E;
    localparam logic [7:0] CH_X   = 8'h58;
    localparam logic [7:0] CH_T   = 8'h54;
    localparam logic [7:0] CH_P   = 8'h50;
    localparam logic [7:0] CH_F   = 8'h46;
    localparam logic [7:0] CH_LF  = 8'h0A;

    localparam int unsigned ADDR_STEP = 4;

    // UART transmit register takes the character in the low byte
    function automatic logic [31:0] uart_word(input logic [7:0] ch);
        return {24'h0, ch};
    endfunction

endpackage

// File: rtl/sdram_test_master_if.sv
// Wishbone master/slave bundle used between the test master and the memory/UART fabric.
interface sdram_test_master_if;
    logic [31:0] wishbone_addr_o;
    logic [31:0] wishbone_data_o;
    logic        wishbone_we_o;
    logic [3:0]  wishbone_sel_o;
    logic        wishbone_stb_o;
    logic        wishbone_cyc_o;
    logic [31:0] wishbone_data_i;
    logic        wishbone_ack_i;

    modport master (
        output wishbone_addr_o, wishbone_data_o, wishbone_we_o, wishbone_sel_o,
               wishbone_stb_o, wishbone_cyc_o,
        input  wishbone_data_i, wishbone_ack_i
    );

    modport slave (
        input  wishbone_addr_o, wishbone_data_o, wishbone_we_o, wishbone_sel_o,
               wishbone_stb_o, wishbone_cyc_o,
        output wishbone_data_i, wishbone_ack_i
    );
endinterface

// File: rtl/sdram_test_master_wb_single_xfer.sv
// One Wishbone classic transfer with an ack timeout; done pulses the cycle after ack/timeout.
module wb_single_xfer #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       go,
    input  logic                       we,
    input  logic [31:0]                addr,
    input  logic [31:0]                wdata,
    output logic                       done,
    output logic                       ok,
    output logic                       timeout,
    output logic [31:0]                rdata,
    sdram_test_master_if.master        wb
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             stb_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      data_q;
    logic [3:0]       sel_q;

    assign wb.wishbone_stb_o  = stb_q;
    assign wb.wishbone_cyc_o  = stb_q;
    assign wb.wishbone_we_o   = we_q;
    assign wb.wishbone_addr_o = addr_q;
    assign wb.wishbone_data_o = data_q;
    assign wb.wishbone_sel_o  = sel_q;

    // Launch on go, hold the strobe until ack or until wait_cnt reaches TIMEOUT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            data_q   <= 32'h0;
            sel_q    <= 4'h0;
            done     <= 1'b0;
            ok       <= 1'b0;
            timeout  <= 1'b0;
            rdata    <= 32'h0;
        end else begin
            done <= 1'b0;
            if (stb_q) begin
                if (wb.wishbone_ack_i) begin
                    stb_q   <= 1'b0;
                    we_q    <= 1'b0;
                    done    <= 1'b1;
                    ok      <= 1'b1;
                    timeout <= 1'b0;
                    rdata   <= wb.wishbone_data_i;
                end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                    stb_q   <= 1'b0;
                    we_q    <= 1'b0;
                    done    <= 1'b1;
                    ok      <= 1'b0;
                    timeout <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            end else if (go) begin
                // Counter holds the number of strobe cycles including the current one
                wait_cnt <= CNT_W'(1);
                stb_q    <= 1'b1;
                we_q     <= we;
                addr_q   <= addr;
                data_q   <= wdata;
                sel_q    <= 4'hF;
            end
        end
    end

endmodule

// File: rtl/sdram_test_master.sv
// Writes a seeded pattern to SDRAM, reads it back, and reports each word over a UART.
module sdram_test_master
    import sdram_test_pkg::*;
#(
    parameter int unsigned NWORDS     = 16,
    parameter logic [31:0] SDRAM_BASE = 32'h0000_0000,
    parameter logic [31:0] UART_ADDR  = 32'h1000_0000,
    parameter logic [31:0] SEED       = 32'h3031_3233,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic [8:0]          err_cnt_o,
    sdram_test_master_if.master wb
);
    localparam int unsigned IDX_W = $clog2(NWORDS) + 1;

    state_t         state_q;
    state_t         state_d;
    print_phase_t   phase_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]    rd_data_q;
    logic           rd_to_q;
    logic [7:0]     char_q;

    logic           xfer_go;
    logic           xfer_we;
    logic [31:0]    xfer_addr;
    logic [31:0]    xfer_wdata;
    logic           x_done;
    logic           x_ok;
    logic           x_to;
    logic [31:0]    x_rdata;

    logic           last_word;
    logic [31:0]    exp_word;
    logic [31:0]    word_addr;
    logic [8:0]     err_inc;

    assign last_word = (idx_q == IDX_W'(NWORDS - 1));
    assign exp_word  = SEED + 32'(idx_q);
    assign word_addr = SDRAM_BASE + 32'(idx_q) * 32'(ADDR_STEP);
    assign err_inc   = (err_cnt_o < 9'(NWORDS)) ? err_cnt_o + 9'd1 : err_cnt_o;

    wb_single_xfer #(
        .TIMEOUT (TIMEOUT)
    ) u_xfer (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (xfer_go),
        .we      (xfer_we),
        .addr    (xfer_addr),
        .wdata   (xfer_wdata),
        .done    (x_done),
        .ok      (x_ok),
        .timeout (x_to),
        .rdata   (x_rdata),
        .wb      (wb)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (start_i) state_d = WR;
            WR:         state_d = WR_WAIT;
            WR_WAIT:    if (x_done) state_d = last_word ? RD : WR;
            RD:         state_d = RD_WAIT;
            RD_WAIT:    if (x_done) state_d = CMP;
            CMP:        state_d = PRINT;
            PRINT:      state_d = PRINT_WAIT;
            PRINT_WAIT: begin
                if (x_done) begin
                    case (phase_q)
                        PR_WORD:    state_d = last_word ? PRINT : RD;
                        PR_VERDICT: state_d = PRINT;
                        default:    state_d = DONE;
                    endcase
                end
            end
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Transfer request for the current state; the sub-module registers it onto the bus
    always_comb begin
        xfer_go    = 1'b0;
        xfer_we    = 1'b0;
        xfer_addr  = word_addr;
        xfer_wdata = exp_word;
        case (state_q)
            WR: begin
                xfer_go = 1'b1;
                xfer_we = 1'b1;
            end
            RD: xfer_go = 1'b1;
            PRINT: begin
                xfer_go   = 1'b1;
                xfer_we   = 1'b1;
                xfer_addr = UART_ADDR;
                case (phase_q)
                    PR_WORD:    xfer_wdata = uart_word(char_q);
                    PR_VERDICT: xfer_wdata = uart_word((err_cnt_o == 9'd0) ? CH_P : CH_F);
                    default:    xfer_wdata = uart_word(CH_LF);
                endcase
            end
            default: ;
        endcase
    end

    // Word index, error count, read capture and status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q     <= '0;
            phase_q   <= PR_WORD;
            rd_data_q <= 32'h0;
            rd_to_q   <= 1'b0;
            char_q    <= 8'h0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            pass_o    <= 1'b0;
            err_cnt_o <= 9'd0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        idx_q     <= '0;
                        err_cnt_o <= 9'd0;
                        busy_o    <= 1'b1;
                        pass_o    <= 1'b0;
                    end
                end
                WR_WAIT: begin
                    if (x_done) begin
                        if (x_to) err_cnt_o <= err_inc;
                        idx_q <= last_word ? '0 : idx_q + IDX_W'(1);
                    end
                end
                RD_WAIT: begin
                    if (x_done) begin
                        rd_data_q <= x_rdata;
                        rd_to_q   <= !x_ok;
                    end
                end
                CMP: begin
                    phase_q <= PR_WORD;
                    if (rd_to_q) begin
                        char_q    <= CH_T;
                        err_cnt_o <= err_inc;
                    end else if (rd_data_q != exp_word) begin
                        char_q    <= CH_X;
                        err_cnt_o <= err_inc;
                    end else begin
                        char_q    <= CH_DOT;
                    end
                end
                PRINT_WAIT: begin
                    if (x_done) begin
                        case (phase_q)
                            PR_WORD: begin
                                if (last_word) phase_q <= PR_VERDICT;
                                else           idx_q   <= idx_q + IDX_W'(1);
                            end
                            PR_VERDICT: phase_q <= PR_LF;
                            default: begin
                                // done_o is high exactly while the FSM sits in DONE
                                done_o <= 1'b1;
                                busy_o <= 1'b0;
                                pass_o <= (err_cnt_o == 9'd0);
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
